// File: rtl/pwm_multi_if.sv
`default_nettype none
// ============================================================================
// Module   : pwm_multi_if
// Brief    : Duty-write strobe bus for pwm_multi (strobe, channel, value).
// Revision : 1.0 - initial release
// ============================================================================
interface pwm_multi_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  localparam int c_ch_w = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic              i_wr;
  logic [c_ch_w-1:0] i_ch;
  logic [WIDTH-1:0]  i_d;

  modport master (output i_wr, i_ch, i_d);
  modport slave  (input  i_wr, i_ch, i_d);
endinterface
`default_nettype wire

// File: rtl/pwm_multi.sv
`default_nettype none
// ============================================================================
// Module   : pwm_multi
// Brief    : Multi-channel PWM with shared period counter, clamped shadow
//            duty registers, glitch-free period-boundary reload, optional
//            phase stagger. Optional fade engine enabled by macro PWM_FADE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_multi #(
  parameter int WIDTH     = 8,
  parameter int CHANNELS  = 4,
  parameter int DMIN      = 0,
  parameter int DMAX      = 255,
  parameter int STAGGER   = 0,
  parameter int FADE_STEP = 4
) (
  input  wire                 sysclk,
  input  wire                 i_rst_n,
  input  wire                 i_enb,
  pwm_multi_if.slave          wr_bus,
  output wire [CHANNELS-1:0]  o_pwm,
  output wire [WIDTH-1:0]     o_cnt,
  output wire                 o_period,
  output wire [CHANNELS-1:0]  o_fading
);

  localparam int               c_ch_w   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [c_ch_w:0]  c_ch_lim = (c_ch_w+1)'(CHANNELS);
  localparam logic [WIDTH-1:0] c_max    = '1;
  localparam logic [WIDTH-1:0] c_one    = WIDTH'(1);
  localparam logic [WIDTH-1:0] c_dmin   = WIDTH'(DMIN);
  localparam logic [WIDTH-1:0] c_dmax   = WIDTH'(DMAX);
  localparam int               c_ofs    = (STAGGER != 0) ? (2**WIDTH) / CHANNELS : 0;

  if (!((CHANNELS >= 1) && (CHANNELS <= 16) && (DMIN >= 0) && (DMIN <= DMAX) &&
        (DMAX < 2**WIDTH) && (FADE_STEP >= 1))) begin : g_bad_params
    $error("pwm_multi: illegal parameter set");
  end

  logic [WIDTH-1:0] r_cnt;
  logic             r_period;
  logic             w_boundary;
  logic             w_wr_ok;
  logic [WIDTH-1:0] w_d_clamp;

  // Counter parks at MAX while disabled so every disabled cycle is a boundary.
  always_ff @(posedge sysclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt    <= c_max;
      r_period <= 1'b0;
    end else if (i_enb) begin
      r_cnt    <= r_cnt + c_one;
      r_period <= (r_cnt == c_max);
    end else begin
      r_cnt    <= c_max;
      r_period <= 1'b0;
    end
  end

  assign w_boundary = (r_cnt == c_max);
  assign w_wr_ok    = wr_bus.i_wr && ({1'b0, wr_bus.i_ch} < c_ch_lim);

  always_comb begin
    w_d_clamp = wr_bus.i_d;
    if (wr_bus.i_d < c_dmin) begin
      w_d_clamp = c_dmin;
    end else if (wr_bus.i_d > c_dmax) begin
      w_d_clamp = c_dmax;
    end
  end

  assign o_cnt    = r_cnt;
  assign o_period = r_period;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    localparam logic [c_ch_w-1:0] c_idx   = c_ch_w'(k);
    localparam logic [WIDTH-1:0]  c_phase = WIDTH'(k * c_ofs);

    logic [WIDTH-1:0] r_shadow;
    logic [WIDTH-1:0] r_active;
    logic             r_pwm;
    logic             r_fading;
    logic [WIDTH-1:0] w_shadow_nxt;
    logic [WIDTH-1:0] w_active_nxt;
    logic [WIDTH-1:0] w_phase;

    assign w_shadow_nxt = (w_wr_ok && (wr_bus.i_ch == c_idx)) ? w_d_clamp : r_shadow;
    assign w_phase      = r_cnt + c_phase;

`ifdef PWM_FADE_EN
    localparam logic [WIDTH-1:0] c_step = WIDTH'(FADE_STEP);
    logic [WIDTH-1:0] w_diff_up;
    logic [WIDTH-1:0] w_diff_dn;

    assign w_diff_up = r_shadow - r_active;
    assign w_diff_dn = r_active - r_shadow;

    // Step toward the shadow by at most c_step, landing exactly on it.
    always_comb begin
      w_active_nxt = r_active;
      if (w_boundary) begin
        if (r_shadow > r_active) begin
          w_active_nxt = (w_diff_up > c_step) ? (r_active + c_step) : r_shadow;
        end else if (r_shadow < r_active) begin
          w_active_nxt = (w_diff_dn > c_step) ? (r_active - c_step) : r_shadow;
        end
      end
    end
`else
    // Active reads the pre-write shadow, so a colliding write lands a period later.
    assign w_active_nxt = w_boundary ? r_shadow : r_active;
`endif

    always_ff @(posedge sysclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_shadow <= c_dmin;
        r_active <= '0;
        r_pwm    <= 1'b0;
        r_fading <= 1'b0;
      end else begin
        r_shadow <= w_shadow_nxt;
        r_active <= w_active_nxt;
        r_pwm    <= i_enb && (w_phase < r_active);
        r_fading <= (w_active_nxt != w_shadow_nxt);
      end
    end

    assign o_pwm[k]    = r_pwm;
    assign o_fading[k] = r_fading;
  end

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_multi
// Brief    : Self-checking bench: default, clamped (3 ch) and staggered DUTs
//            share one write bus; per-period high counts are scoreboarded.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_multi;

  logic sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  logic rst_n;
  logic enb;

  pwm_multi_if #(.WIDTH(8), .CHANNELS(4)) wif ();

  wire [3:0] pwm0, fad0, pwm2, fad2;
  wire [2:0] pwm1, fad1;
  wire [7:0] cnt0, cnt1, cnt2;
  wire       per0, per1, per2;

  pwm_multi u_dut0 (
    .sysclk(sysclk), .i_rst_n(rst_n), .i_enb(enb), .wr_bus(wif),
    .o_pwm(pwm0), .o_cnt(cnt0), .o_period(per0), .o_fading(fad0));

  pwm_multi #(.CHANNELS(3), .DMIN(16), .DMAX(240)) u_dut1 (
    .sysclk(sysclk), .i_rst_n(rst_n), .i_enb(enb), .wr_bus(wif),
    .o_pwm(pwm1), .o_cnt(cnt1), .o_period(per1), .o_fading(fad1));

  pwm_multi #(.STAGGER(1)) u_dut2 (
    .sysclk(sysclk), .i_rst_n(rst_n), .i_enb(enb), .wr_bus(wif),
    .o_pwm(pwm2), .o_cnt(cnt2), .o_period(per2), .o_fading(fad2));

  int n_tests = 0;
  int n_fail  = 0;

  int nch  [3] = '{4, 3, 4};
  int dmin [3] = '{0, 16, 0};
  int dmax [3] = '{255, 240, 255};
  int ofs  [3] = '{0, 0, 64};
  int sh_m [3][4];
  int ac_m [3][4];

  typedef struct { int dut; int ch; int duty; } exp_t;
  exp_t sb[$];

  typedef struct { int ch; int d; } vec_t;
  vec_t vecs[6];

  function automatic logic [3:0] get_pwm(input int d);
    case (d)
      0:       return pwm0;
      1:       return {1'b0, pwm1};
      default: return pwm2;
    endcase
  endfunction

  function automatic logic [3:0] get_fad(input int d);
    case (d)
      0:       return fad0;
      1:       return {1'b0, fad1};
      default: return fad2;
    endcase
  endfunction

  function automatic int get_cnt(input int d);
    case (d)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      default: return int'(cnt2);
    endcase
  endfunction

  function automatic int get_per(input int d);
    case (d)
      0:       return int'(per0);
      1:       return int'(per1);
      default: return int'(per2);
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int clamp(input int d, input int x);
    if (x < dmin[d]) return dmin[d];
    if (x > dmax[d]) return dmax[d];
    return x;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++)
      for (int c = 0; c < 4; c++) begin
        sh_m[d][c] = dmin[d];
        ac_m[d][c] = 0;
      end
  endtask

  task automatic model_write(input int ch, input int x);
    for (int d = 0; d < 3; d++)
      if (ch < nch[d]) sh_m[d][ch] = clamp(d, x);
  endtask

  task automatic model_boundary();
    for (int d = 0; d < 3; d++)
      for (int c = 0; c < nch[d]; c++) begin
`ifdef PWM_FADE_EN
        if (sh_m[d][c] > ac_m[d][c])
          ac_m[d][c] += (sh_m[d][c] - ac_m[d][c] > 4) ? 4 : sh_m[d][c] - ac_m[d][c];
        else
          ac_m[d][c] -= (ac_m[d][c] - sh_m[d][c] > 4) ? 4 : ac_m[d][c] - sh_m[d][c];
`else
        ac_m[d][c] = sh_m[d][c];
`endif
      end
  endtask

  function automatic logic model_settled();
    for (int d = 0; d < 3; d++)
      for (int c = 0; c < nch[d]; c++)
        if (ac_m[d][c] != sh_m[d][c]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int model_fad(input int d);
    int v = 0;
    for (int c = 0; c < nch[d]; c++)
      if (ac_m[d][c] != sh_m[d][c]) v |= (1 << c);
    return v;
  endfunction

  task automatic check_fading(input string tag);
    for (int d = 0; d < 3; d++)
      check($sformatf("%s_fading_dut%0d", tag, d), int'(get_fad(d)), model_fad(d));
  endtask

  task automatic push_all();
    for (int d = 0; d < 3; d++)
      for (int c = 0; c < nch[d]; c++)
        sb.push_back('{d, c, ac_m[d][c]});
  endtask

  task automatic wait_cnt(input int v);
    int n = 0;
    while (int'(cnt0) != v && n < 600) begin
      @(negedge sysclk);
      n++;
    end
    if (int'(cnt0) != v) check("wait_cnt_timeout", int'(cnt0), v);
  endtask

  task automatic do_write(input int ch, input int x);
    wif.i_wr = 1'b1;
    wif.i_ch = ch[1:0];
    wif.i_d  = x[7:0];
    @(negedge sysclk);
    wif.i_wr = 1'b0;
  endtask

  // Window spans visible cnt 1..255 then 0: one full period at 1-cycle latency.
  task automatic measure(input string tag, input bit onehot);
    int   hi [3][4];
    int   pat_err = 0;
    int   per_err = 0;
    int   multi   = 0;
    int   c;
    logic [3:0] p;
    logic       eb;
    exp_t e;
    for (int d = 0; d < 3; d++)
      for (int k = 0; k < 4; k++) hi[d][k] = 0;
    wait_cnt(1);
    for (int i = 0; i < 256; i++) begin
      if (i > 0) @(negedge sysclk);
      for (int d = 0; d < 3; d++) begin
        p = get_pwm(d);
        c = get_cnt(d);
        if (get_per(d) != ((c == 0) ? 1 : 0)) per_err++;
        for (int k = 0; k < nch[d]; k++) begin
          if (p[k]) hi[d][k]++;
          eb = (((c - 1 + k * ofs[d]) & 255) < ac_m[d][k]);
          if (p[k] != eb) pat_err++;
        end
        if (d == 2 && $countones(p) > 1) multi++;
      end
    end
    check({tag, "_pattern"}, pat_err, 0);
    check({tag, "_period"}, per_err, 0);
    if (onehot) check({tag, "_onehot"}, multi, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("%s_duty_dut%0d_ch%0d", tag, e.dut, e.ch), hi[e.dut][e.ch], e.duty);
    end
    model_boundary();
    check_fading(tag);
  endtask

  task automatic settle();
    int it = 0;
    while (!model_settled() && it < 80) begin
      push_all();
      measure("settle", 1'b0);
      it++;
    end
  endtask

  task automatic round(input string tag, input int ch, input int x);
    wait_cnt(128);
    do_write(ch, x);
    model_write(ch, x);
    check_fading({tag, "_wr"});
    model_boundary();
    push_all();
    measure(tag, 1'b0);
  endtask

  initial begin
    int nb;
    vecs[0] = '{1, 5};
    vecs[1] = '{1, 250};
    vecs[2] = '{3, 77};
    vecs[3] = '{3, 255};
    vecs[4] = '{2, 32};
    vecs[5] = '{0, 0};

    rst_n = 1'b0; enb = 1'b0;
    wif.i_wr = 1'b0; wif.i_ch = '0; wif.i_d = '0;
    model_reset();
    repeat (3) @(negedge sysclk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_cnt_dut%0d", d), get_cnt(d), 255);
      check($sformatf("rst_pwm_dut%0d", d), int'(get_pwm(d)), 0);
      check($sformatf("rst_per_dut%0d", d), get_per(d), 0);
      check($sformatf("rst_fad_dut%0d", d), int'(get_fad(d)), 0);
    end

    // Run part of a period, then assert reset asynchronously between edges.
    rst_n = 1'b1; enb = 1'b1;
    repeat (100) @(negedge sysclk);
    #3 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("async_rst_cnt_dut%0d", d), get_cnt(d), 255);
      check($sformatf("async_rst_pwm_dut%0d", d), int'(get_pwm(d)), 0);
    end
    model_reset();
    enb = 1'b0;
    @(negedge sysclk);
    rst_n = 1'b1;
    begin
      int bad [3] = '{0, 0, 0};
      for (int i = 0; i < 20; i++) begin
        @(negedge sysclk);
        for (int d = 0; d < 3; d++)
          if (get_cnt(d) != 255 || get_pwm(d) != 0 || get_per(d) != 0 || get_fad(d) != 0)
            bad[d]++;
      end
      for (int d = 0; d < 3; d++) check($sformatf("disabled_dut%0d", d), bad[d], 0);
    end

    // Basic duty: program while disabled, then enable.
    do_write(0, 64);
    model_write(0, 64);
    repeat (80) @(negedge sysclk);
    for (int d = 0; d < 3; d++)
      for (int c = 0; c < 4; c++) ac_m[d][c] = sh_m[d][c];
    enb = 1'b1;
    @(negedge sysclk);
    check("en_cnt0", int'(cnt0), 0);
    check("en_period", int'(per0), 1);
    check("en_pwm_lat", int'(pwm0[0]), 0);
    @(negedge sysclk);
    check("en_pwm_rise", int'(pwm0[0]), 1);
    push_all();
    measure("basic", 1'b0);

    for (int i = 0; i < 6; i++)
      round($sformatf("vec%0d", i), vecs[i].ch, vecs[i].d);
    settle();

    // Write to ch2 on the boundary cycle: old value for one more period.
    wait_cnt(255);
    do_write(2, 128);
    model_boundary();
    model_write(2, 128);
    push_all();
    measure("coll_a", 1'b0);
    push_all();
    measure("coll_b", 1'b0);
    settle();

    wait_cnt(100);
    for (int k = 0; k < 4; k++) begin
      do_write(k, 64);
      model_write(k, 64);
    end
    model_boundary();
    settle();
    push_all();
    measure("stagger", 1'b1);

    round("fade_pre", 0, 0);
    settle();
    wait_cnt(128);
    do_write(0, 102);
    model_write(0, 102);
    check("fade_flag_set", int'(fad0[0]), 1);
    nb = 0;
    while (fad0[0] && nb < 40) begin
      wait_cnt(0);
      nb++;
      model_boundary();
      check($sformatf("fade_flag_b%0d", nb), int'(fad0), model_fad(0));
      @(negedge sysclk);
    end
`ifdef PWM_FADE_EN
    check("fade_boundaries", nb, 26);
`else
    check("fade_boundaries", nb, 1);
`endif
    push_all();
    measure("fade_final", 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
